// File: rtl/ecc_pkg.sv
// Shared types and constants for the SECDED encode/decode core.
package ecc_pkg;

   localparam int CW_MAX   = 32;
   localparam int DATA_MAX = 26;

   typedef enum logic [1:0] {
      OP_ENC  = 2'b00,
      OP_DEC  = 2'b01,
      OP_FULL = 2'b10
   } op_e;

   typedef enum logic [1:0] {
      CW_8  = 2'b00,
      CW_16 = 2'b01,
      CW_32 = 2'b10
   } cw_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [3:0] ADDR_CTRL     = 4'h0;
   localparam logic [3:0] ADDR_DATA_IN  = 4'h4;
   localparam logic [3:0] ADDR_CW_WIDTH = 4'h8;
   localparam logic [3:0] ADDR_NOISE    = 4'hC;

   localparam logic [1:0] NERR_NONE = 2'b00;
   localparam logic [1:0] NERR_ONE  = 2'b01;
   localparam logic [1:0] NERR_TWO  = 2'b10;

   // Codeword length in bits for a width selection.
   function automatic int cw_bits(input cw_e w);
      case (w)
         CW_8:    return 8;
         CW_16:   return 16;
         default: return 32;
      endcase
   endfunction

endpackage

// File: rtl/ecc_hamming_core.sv
// Combinational extended-Hamming SECDED datapath: encode, optional noise
// injection, syndrome, single-bit correction and error classification.
// Codeword bit pos-1 holds Hamming position pos; bit W-1 is overall parity.
module ecc_hamming_core
   import ecc_pkg::*;
(
   input  op_e                 op,
   input  cw_e                 width,
   input  logic [CW_MAX-1:0]   data_in,
   input  logic [CW_MAX-1:0]   noise,
   output logic [CW_MAX-1:0]   result,
   output logic [1:0]          num_err
);

   // Bit index i carries Hamming position i+1; powers of two are parity.
   function automatic logic is_parity_pos(input int i);
      return ((i + 1) & i) == 0;
   endfunction

   function automatic logic [CW_MAX-1:0] encode(input logic [DATA_MAX-1:0] data, input int w);
      logic [CW_MAX-1:0] cw;
      logic [4:0]        k;
      logic              par;
      cw = '0;
      k  = '0;
      for (int i = 0; i < CW_MAX - 1; i++) begin
         if (i < w - 1 && !is_parity_pos(i)) begin
            cw[i] = data[k];
            k     = k + 5'd1;
         end
      end
      for (int p = 0; p < 5; p++) begin
         par = 1'b0;
         for (int i = 0; i < CW_MAX - 1; i++) begin
            if (i < w - 1 && (((i + 1) >> p) & 1) == 1) par = par ^ cw[i];
         end
         if ((1 << p) < w) cw[(1 << p) - 1] = par;
      end
      cw[w - 1] = ^cw;
      return cw;
   endfunction

   function automatic logic [DATA_MAX-1:0] extract(input logic [CW_MAX-1:0] cw, input int w);
      logic [DATA_MAX-1:0] data;
      logic [4:0]          k;
      data = '0;
      k    = '0;
      for (int i = 0; i < CW_MAX - 1; i++) begin
         if (i < w - 1 && !is_parity_pos(i)) begin
            data[k] = cw[i];
            k       = k + 5'd1;
         end
      end
      return data;
   endfunction

   int                  w;
   logic [CW_MAX-1:0]   mask;
   logic [CW_MAX-1:0]   enc_cw;
   logic [CW_MAX-1:0]   dec_cw;
   logic [CW_MAX-1:0]   corrected;
   logic [4:0]          syn;
   logic                overall;
   logic [1:0]          err;

   // Data bits above the 26-bit maximum payload never reach the codeword.
   logic unused_data_hi;
   assign unused_data_hi = ^data_in[CW_MAX-1:DATA_MAX];

   // Full datapath; op selects whether the decoder sees DATA_IN or the noisy encode.
   always_comb begin
      w         = cw_bits(width);
      mask      = (w == CW_MAX) ? '1 : ((32'd1 << w) - 32'd1);
      enc_cw    = encode(data_in[DATA_MAX-1:0], w);
      dec_cw    = (op == OP_FULL) ? ((enc_cw ^ noise) & mask) : (data_in & mask);
      syn       = '0;
      for (int i = 0; i < CW_MAX - 1; i++) begin
         if (i < w - 1 && dec_cw[i]) syn = syn ^ 5'(i + 1);
      end
      overall   = ^dec_cw;
      corrected = dec_cw;
      err       = NERR_NONE;
      if (overall) begin
         err = NERR_ONE;
         // Zero syndrome with bad overall parity means only the parity bit flipped.
         if (syn != 5'd0) corrected[syn - 5'd1] = ~corrected[syn - 5'd1];
      end else if (syn != 5'd0) begin
         err = NERR_TWO;
      end
      if (op == OP_ENC) begin
         result  = enc_cw;
         num_err = NERR_NONE;
      end else begin
         result  = {{(CW_MAX-DATA_MAX){1'b0}}, extract(corrected, w)};
         num_err = err;
      end
   end

endmodule

// File: rtl/ecc_enc_dec_core.sv
// APB-programmed SECDED encode/decode/channel engine.
// Optional feature: define ECC_APB_READBACK_EN to enable register readback on PRDATA.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | accepting APB writes; CTRL write launches an op
// CALC    | registers frozen, hamming core settling
// DONE    | results captured, operation_done high one cycle
module ecc_enc_dec_core
   import ecc_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic                       PENABLE,
   input  logic                       PSEL,
   input  logic                       PWRITE,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       operation_done,
   output logic [1:0]                 num_of_errors
);

   logic [1:0]        ctrl_q;
   logic [1:0]        cw_width_q;
   logic [CW_MAX-1:0] data_in_q;
   logic [CW_MAX-1:0] noise_q;
   state_e            state_q;
   state_e            state_d;
   logic              wr_en;
   logic              ctrl_wr;
   op_e               op_eff;
   cw_e               cw_eff;
   logic [CW_MAX-1:0] core_result;
   logic [1:0]        core_nerr;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic [1:0]        nerr_q;

   // Only PADDR[3:0] and the low word of PWDATA are meaningful.
   logic unused_apb;
   assign unused_apb = ^{PADDR, PWDATA};

   assign wr_en   = PSEL & PENABLE & PWRITE & (state_q == ST_IDLE);
   assign ctrl_wr = wr_en & (PADDR[3:0] == ADDR_CTRL);

   // Reserved encodings alias onto decode and 32-bit width.
   assign op_eff = (ctrl_q == 2'b11) ? OP_DEC : op_e'(ctrl_q);
   assign cw_eff = (cw_width_q == 2'b11) ? CW_32 : cw_e'(cw_width_q);

   // Register file; writes land only while idle so operands stay stable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q     <= '0;
         cw_width_q <= '0;
         data_in_q  <= '0;
         noise_q    <= '0;
      end else if (wr_en) begin
         case (PADDR[3:0])
            ADDR_CTRL:     ctrl_q     <= PWDATA[1:0];
            ADDR_DATA_IN:  data_in_q  <= PWDATA[CW_MAX-1:0];
            ADDR_CW_WIDTH: cw_width_q <= PWDATA[1:0];
            ADDR_NOISE:    noise_q    <= PWDATA[CW_MAX-1:0];
            default: ;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (ctrl_wr) state_d = ST_CALC;
         ST_CALC: state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   ecc_hamming_core u_core (
      .op      (op_eff),
      .width   (cw_eff),
      .data_in (data_in_q),
      .noise   (noise_q),
      .result  (core_result),
      .num_err (core_nerr)
   );

   // Capture results on the CALC->DONE edge; they hold until the next op.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_q <= '0;
         nerr_q     <= NERR_NONE;
      end else if (state_q == ST_CALC) begin
         data_out_q <= DATA_WIDTH'(core_result);
         nerr_q     <= core_nerr;
      end
   end

   assign data_out       = data_out_q;
   assign num_of_errors  = nerr_q;
   assign operation_done = (state_q == ST_DONE);

`ifdef ECC_APB_READBACK_EN
   logic [AMBA_WORD-1:0] prdata_d;

   // Combinational readback in the access cycle; unmapped offsets read zero.
   always_comb begin
      prdata_d = '0;
      if (PSEL && PENABLE && !PWRITE) begin
         case (PADDR[3:0])
            ADDR_CTRL:     prdata_d = AMBA_WORD'(ctrl_q);
            ADDR_DATA_IN:  prdata_d = AMBA_WORD'(data_in_q);
            ADDR_CW_WIDTH: prdata_d = AMBA_WORD'(cw_width_q);
            ADDR_NOISE:    prdata_d = AMBA_WORD'(noise_q);
            default:       prdata_d = '0;
         endcase
      end
   end

   assign PRDATA = prdata_d;
`else
   assign PRDATA = '0;
`endif

endmodule

// File: tb/tb_ecc_enc_dec_core.sv
// Directed bench for ecc_enc_dec_core with hand-computed SECDED vectors.
module tb_ecc_enc_dec_core;

   logic        clk;
   logic        rst;
   logic [19:0] PADDR;
   logic        PENABLE;
   logic        PSEL;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic [31:0] data_out;
   logic        operation_done;
   logic [1:0]  num_of_errors;

   int checks   = 0;
   int failures = 0;
   int pulses;

   ecc_enc_dec_core #(
      .DATA_WIDTH      (32),
      .AMBA_ADDR_WIDTH (20),
      .AMBA_WORD       (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .PADDR          (PADDR),
      .PENABLE        (PENABLE),
      .PSEL           (PSEL),
      .PWRITE         (PWRITE),
      .PWDATA         (PWDATA),
      .PRDATA         (PRDATA),
      .data_out       (data_out),
      .operation_done (operation_done),
      .num_of_errors  (num_of_errors)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the access edge.
   task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
      PADDR   = {16'h0, a};
      PWDATA  = d;
      PWRITE  = 1'b1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      @(negedge clk);
      PENABLE = 1'b1;
      @(negedge clk);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
   endtask

   task automatic apb_read_check(input string tag, input logic [19:0] a, input logic [31:0] exp);
      PADDR   = a;
      PWRITE  = 1'b0;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      @(negedge clk);
      PENABLE = 1'b1;
      #1;
      check(tag, PRDATA, exp);
      @(negedge clk);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
   endtask

   // Launch an op and check the single done pulse two cycles after the CTRL access.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] exp_data, input logic [1:0] exp_nerr);
      apb_write(4'h0, {30'd0, op});
      check({tag, "_done_calc"}, {31'd0, operation_done}, 32'd0);
      @(negedge clk);
      check({tag, "_done"}, {31'd0, operation_done}, 32'd1);
      check({tag, "_data"}, data_out, exp_data);
      check({tag, "_nerr"}, {30'd0, num_of_errors}, {30'd0, exp_nerr});
      @(negedge clk);
      check({tag, "_done_after"}, {31'd0, operation_done}, 32'd0);
      check({tag, "_data_hold"}, data_out, exp_data);
   endtask

   initial begin
      rst     = 1'b0;
      PADDR   = '0;
      PENABLE = 1'b0;
      PSEL    = 1'b0;
      PWRITE  = 1'b0;
      PWDATA  = '0;
      #1;
      check("rst_data",   data_out, 32'd0);
      check("rst_done",   {31'd0, operation_done}, 32'd0);
      check("rst_nerr",   {30'd0, num_of_errors}, 32'd0);
      check("rst_prdata", PRDATA, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 8-bit codewords
      apb_write(4'h8, 32'd0);
      apb_write(4'h4, 32'hB);
      run_op("enc8", 2'b00, 32'h55, 2'b00);
      apb_write(4'h4, 32'h51);
      run_op("dec8_1err", 2'b01, 32'hB, 2'b01);
      apb_write(4'h4, 32'h50);
      run_op("dec8_2err", 2'b01, 32'hA, 2'b10);
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (operation_done) pulses++;
      end
      check("dec8_2err_extra_pulses", pulses, 0);
      apb_write(4'h4, 32'h55);
      run_op("dec8_clean", 2'b01, 32'hB, 2'b00);
      apb_write(4'h4, 32'hD5);
      run_op("dec8_par_err", 2'b01, 32'hB, 2'b01);
      apb_write(4'h4, 32'hFFFF_FF51);
      run_op("dec8_upper_ign", 2'b01, 32'hB, 2'b01);
      apb_write(4'h4, 32'h51);
      run_op("op11_dec", 2'b11, 32'hB, 2'b01);
      apb_write(4'h4, 32'hB);
      apb_write(4'hC, 32'hFFFF_FF03);
      run_op("full8_2err", 2'b10, 32'hB, 2'b10);

      // 16-bit codewords
      apb_write(4'h8, 32'd1);
      apb_write(4'h4, 32'h7FF);
      run_op("enc16", 2'b00, 32'hFFFF, 2'b00);
      apb_write(4'h4, 32'hFDFF);
      run_op("dec16_1err", 2'b01, 32'h7FF, 2'b01);

      // 32-bit codewords
      apb_write(4'h8, 32'd2);
      apb_write(4'h4, 32'h3FF_FFFF);
      run_op("enc32", 2'b00, 32'hFFFF_FFFF, 2'b00);
      apb_write(4'hC, 32'h1);
      run_op("full32_1err", 2'b10, 32'h3FF_FFFF, 2'b01);

      // Reset during CALC abandons the op
      apb_write(4'h8, 32'd0);
      apb_write(4'h4, 32'hB);
      apb_write(4'h0, 32'd0);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_data", data_out, 32'd0);
      check("midrst_nerr", {30'd0, num_of_errors}, 32'd0);
      check("midrst_done", {31'd0, operation_done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (operation_done) pulses++;
      end
      check("midrst_pulses", pulses, 0);
      check("midrst_data_after", data_out, 32'd0);

      // Width code 11 behaves as 32
      apb_write(4'h8, 32'd3);
      apb_write(4'h4, 32'h3FF_FFFF);
      run_op("cw11_enc", 2'b00, 32'hFFFF_FFFF, 2'b00);

      // DATA_IN write during CALC is dropped
      apb_write(4'h8, 32'd0);
      apb_write(4'h4, 32'hB);
      apb_write(4'h0, 32'd0);
      PADDR   = 20'h4;
      PWDATA  = 32'h3;
      PWRITE  = 1'b1;
      PSEL    = 1'b1;
      PENABLE = 1'b1;
      @(negedge clk);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      check("busy_wr_done", {31'd0, operation_done}, 32'd1);
      check("busy_wr_data", data_out, 32'h55);
      @(negedge clk);
      run_op("enc8_old_data", 2'b00, 32'h55, 2'b00);

`ifdef ECC_APB_READBACK_EN
      apb_write(4'hC, 32'h5);
      apb_read_check("rd_noise", 20'hC, 32'h5);
      apb_read_check("rd_0x10", 20'h10, 32'h0);
      apb_read_check("rd_unmapped", 20'h2, 32'h0);
      apb_read_check("rd_data_in", 20'h4, 32'hB);
`else
      apb_write(4'hC, 32'h5);
      apb_read_check("rd_noise_off", 20'hC, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ecc_enc_dec_core.md
ECC_ENC_DEC_CORE -- requirements
Module: ecc_enc_dec_core

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of data_out and of the internal data/codeword path.
- REQ-002 SHALL have parameter AMBA_ADDR_WIDTH, default 20, the APB address width.
- REQ-003 SHALL have parameter AMBA_WORD, default 32, the APB data width.
- REQ-004 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
- REQ-005 SHALL have port rst, input, 1, reset, asynchronous assertion, active-low.
- REQ-006 SHALL have port PADDR, input, AMBA_ADDR_WIDTH, APB address; only PADDR[3:0] is decoded.
- REQ-007 SHALL have port PENABLE, input, 1, APB access phase.
- REQ-008 SHALL have port PSEL, input, 1, APB select.
- REQ-009 SHALL have port PWRITE, input, 1, APB direction (1 = write).
- REQ-010 SHALL have port PWDATA, input, AMBA_WORD, APB write data.
- REQ-011 SHALL have port PRDATA, output, AMBA_WORD, APB read data.
- REQ-012 SHALL have port data_out, output, DATA_WIDTH, operation result.
- REQ-013 SHALL have port operation_done, output, 1, one-cycle completion pulse.
- REQ-014 SHALL have port num_of_errors, output, 2, error count: 00 none, 01 one (corrected), 10 two (uncorrectable), 11 never driven.

Function
- REQ-015 SHALL decode these registers on PADDR[3:0]: CTRL 0x0 (bits[1:0]: 00 encode, 01 decode, 10 full channel); DATA_IN 0x4; CODEWORD_WIDTH 0x8 (bits[1:0]: 00 = 8, 01 = 16, 10 = 32); NOISE 0xC.
- REQ-016 SHALL latch a register write on a cycle with PSEL & PENABLE & PWRITE; writes to any other offset are ignored.
- REQ-017 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE; a CTRL write in IDLE moves the FSM to CALC on the next edge.
- REQ-018 SHALL ignore all APB writes while the FSM is not in IDLE.
- REQ-019 SHALL assert operation_done for exactly one cycle, in DONE, two cycles after the CTRL write access cycle; data_out and num_of_errors update on that same edge and hold until the next DONE.
- REQ-020 SHALL use extended Hamming SECDED with codeword widths 8/16/32 carrying 4/11/26 data bits.
- REQ-021 SHALL use this codeword layout: bits[W-2:0] hold Hamming positions 1..W-1 at bit index pos-1, parity bits sit at power-of-two positions, data bits fill the remaining positions in ascending order from data LSB, and bit W-1 is even overall parity.
- REQ-022 encode SHALL place the codeword, zero-extended, on data_out and set num_of_errors = 00.
- REQ-023 decode SHALL take the low W bits of DATA_IN as the codeword and output the corrected data, zero-extended.
- REQ-024 for an uncorrectable (two-bit) error, decode SHALL output the uncorrected extracted data bits.
- REQ-025 full channel SHALL encode DATA_IN, XOR the result with NOISE[W-1:0], then decode.
- REQ-026 SHALL ignore DATA_IN and NOISE bits above W.
- REQ-027 SHALL treat CODEWORD_WIDTH = 11 as 32.
- REQ-028 SHALL treat CTRL op = 11 as decode.

Reset
- REQ-029 SHALL, when rst = 0, immediately clear all registers, set the FSM to IDLE, and drive data_out = 0, operation_done = 0, num_of_errors = 00 and PRDATA = 0.
- REQ-030 SHALL abandon any in-flight operation when reset asserts mid-operation, with no operation_done pulse after release.

Configuration
- REQ-031 with ECC_APB_READBACK_EN defined, a read (PSEL & PENABLE & !PWRITE) SHALL return the addressed register zero-extended on PRDATA combinationally in the access cycle; unmapped offsets return 0.
- REQ-032 without ECC_APB_READBACK_EN, PRDATA SHALL be constant 0 and no read mux is synthesised.

Structure
- REQ-033 SHALL take from package ecc_pkg: op enum (OP_ENC, OP_DEC, OP_FULL), width enum (CW_8, CW_16, CW_32), register offset constants, FSM state enum and num_of_errors encodings.
- REQ-034 SHALL use one combinational sub-module, ecc_hamming_core, performing encode, syndrome, correction and error classification for a selected width; the top holds the APB registers, FSM and output registers.

Verification
- REQ-035 Encode, width 8, DATA_IN = 0xB -> operation_done 2 cycles after the CTRL write, data_out = 0x55, num_of_errors = 00.
- REQ-036 Decode, width 8, DATA_IN = 0x51 -> data_out = 0xB, num_of_errors = 01.
- REQ-037 Decode, width 8, DATA_IN = 0x50 -> num_of_errors = 10, exactly one operation_done pulse.
- REQ-038 Full channel, width 32, DATA_IN = 0x3FFFFFF, NOISE = 0x00000001 -> data_out = 0x3FFFFFF, num_of_errors = 01.
- REQ-039 Reset pulse during CALC -> outputs go to 0 asynchronously, no operation_done afterwards; a DATA_IN write during CALC is ignored, so a following encode uses the old value.
- REQ-040 With ECC_APB_READBACK_EN: write NOISE = 0x5, read 0xC -> PRDATA = 0x5; read 0x10 -> PRDATA = 0.
